pattern_frame_gen: RTL and testbench

- Synthesizable test-pattern video source. Emits raster frames with valid/lvalid/fvalid/sof/eof, pixel coordinates and 24-bit RGB.
- Sits directly upstream of the VFP pixel pipeline and feeds its rgb/pattern input channel.
- Replaces D5M camera timing in simulation and board bring-up.

---
 rtl/pattern_frame_gen.sv | 170 +++++++++++++++++
 tb/tb_pattern_frame_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_frame_gen.sv
// Test-pattern raster source: ramp or constant-colour frames with sof/eof and
// pixel coordinates. Define PATTERN_BORDER_EN to force a white one-pixel frame border.
module pattern_frame_gen #(
    parameter int IMG_WIDTH   = 100,
    parameter int LVAL_LINES  = 5,
    parameter int LVAL_OFFSET = 10,
    parameter int NUM_FRAMES  = 1,
    parameter int CORD_WIDTH  = 12
) (
    input  logic                  clkmm,
    input  logic                  rst_l,
    input  logic                  iReadyToRead,
    input  logic                  iImageTypeTest,
    input  logic [7:0]            iRed,
    input  logic [7:0]            iGreen,
    input  logic [7:0]            iBlue,
    output logic                  oValid,
    output logic                  oLvalid,
    output logic                  oFvalid,
    output logic                  oSof,
    output logic                  oEof,
    output logic [23:0]           oRgb,
    output logic [CORD_WIDTH-1:0] oX,
    output logic [CORD_WIDTH-1:0] oY,
    output logic                  oDone
);
    typedef enum logic [2:0] {IDLE, FSTART, ACTIVE, LBLANK, FGAP, DONE} state_t;

    localparam logic [CORD_WIDTH-1:0] X_LAST = CORD_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CORD_WIDTH-1:0] Y_LAST = CORD_WIDTH'(LVAL_LINES - 1);
    localparam logic [15:0]           B_LAST = 16'(LVAL_OFFSET - 1);
    localparam logic [15:0]           NF     = 16'(NUM_FRAMES);

    state_t                state_q, state_d;
    logic [CORD_WIDTH-1:0] col_q, col_d, row_q, row_d;
    logic [15:0]           bcnt_q, bcnt_d, fcnt_q, fcnt_d;
    logic                  type_q, type_d;
    logic [23:0]           colour_q, colour_d;
    logic                  valid_q, valid_d, lvalid_q, lvalid_d, fvalid_q, fvalid_d;
    logic                  sof_q, sof_d, eof_q, eof_d, done_q, done_d;
    logic [23:0]           rgb_q, rgb_d, pix_rgb;
    logic [CORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic                  line_end, last_row;
    logic [7:0]            xb, yb;

    // The line ends on the edge after its last pixel was actually emitted.
    assign line_end = valid_q && (x_q == X_LAST);
    assign last_row = (row_q == Y_LAST);
    assign xb       = 8'(col_q);
    assign yb       = 8'(row_q);

    always_comb begin
        pix_rgb = type_q ? colour_q : {xb, yb, xb ^ yb};
`ifdef PATTERN_BORDER_EN
        if (col_q == '0 || col_q == X_LAST || row_q == '0 || last_row)
            pix_rgb = 24'hFFFFFF;
`endif
    end

    always_ff @(posedge clkmm or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            bcnt_q   <= '0;
            fcnt_q   <= '0;
            type_q   <= 1'b0;
            colour_q <= '0;
            valid_q  <= 1'b0;
            lvalid_q <= 1'b0;
            fvalid_q <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            done_q   <= 1'b0;
            rgb_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            bcnt_q   <= bcnt_d;
            fcnt_q   <= fcnt_d;
            type_q   <= type_d;
            colour_q <= colour_d;
            valid_q  <= valid_d;
            lvalid_q <= lvalid_d;
            fvalid_q <= fvalid_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            done_q   <= done_d;
            rgb_q    <= rgb_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iReadyToRead) state_d = FSTART;
            FSTART:  state_d = ACTIVE;
            ACTIVE:  if (line_end) state_d = last_row ? FGAP : LBLANK;
            LBLANK:  if (bcnt_q == B_LAST) state_d = ACTIVE;
            FGAP:    if (bcnt_q == B_LAST)
                         state_d = (NUM_FRAMES == 0 || fcnt_q < NF) ? FSTART : DONE;
            DONE:    if (!iReadyToRead) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        fcnt_d   = fcnt_q;
        type_d   = type_q;
        colour_d = colour_q;
        rgb_d    = rgb_q;
        x_d      = x_q;
        y_d      = y_q;
        valid_d  = 1'b0;
        sof_d    = 1'b0;
        eof_d    = 1'b0;
        lvalid_d = (state_d == ACTIVE);
        fvalid_d = (state_d == FSTART) || (state_d == ACTIVE) || (state_d == LBLANK);
        done_d   = (state_d == DONE);
        bcnt_d   = '0;
        if (state_d == state_q && (state_q == LBLANK || state_q == FGAP))
            bcnt_d = bcnt_q + 16'd1;
        if (state_q == IDLE && state_d == FSTART)
            fcnt_d = '0;
        if (state_d == FSTART) begin
            col_d    = '0;
            row_d    = '0;
            x_d      = '0;
            y_d      = '0;
            type_d   = iImageTypeTest;
            colour_d = {iRed, iGreen, iBlue};
        end
        if (state_q == ACTIVE && state_d == LBLANK)
            row_d = row_q + 1'b1;
        // Free-running runs let this wrap at 16 bits.
        if (state_q == ACTIVE && state_d == FGAP)
            fcnt_d = fcnt_q + 16'd1;
        if (state_d == ACTIVE) begin
            if (iReadyToRead) begin
                valid_d = 1'b1;
                x_d     = col_q;
                y_d     = row_q;
                rgb_d   = pix_rgb;
                sof_d   = (col_q == '0) && (row_q == '0);
                eof_d   = (col_q == X_LAST) && last_row;
                col_d   = (col_q == X_LAST) ? '0 : col_q + 1'b1;
            end else begin
                sof_d = sof_q;
                eof_d = eof_q;
            end
        end
    end

    assign oValid  = valid_q;
    assign oLvalid = lvalid_q;
    assign oFvalid = fvalid_q;
    assign oSof    = sof_q;
    assign oEof    = eof_q;
    assign oRgb    = rgb_q;
    assign oX      = x_q;
    assign oY      = y_q;
    assign oDone   = done_q;
endmodule

// File: tb/tb_pattern_frame_gen.sv
// Directed bench for pattern_frame_gen: one-shot instance (defaults) plus a
// free-running instance (NUM_FRAMES=0) sharing the same stimulus.
module tb_pattern_frame_gen;
    logic        clkmm = 1'b0;
    logic        rst_l, rdy, typ;
    logic [7:0]  red, grn, blu;
    logic        oValid, oLvalid, oFvalid, oSof, oEof, oDone;
    logic [23:0] oRgb;
    logic [11:0] oX, oY;
    logic        fValid, fLvalid, fFvalid, fSof, fEof, fDone;
    logic [23:0] fRgb;
    logic [11:0] fX, fY;

    int vecs = 0, errs = 0;
    int t_sof, t_done, nval, nsof, neof, nlines, lmin, lmax, gmin, gmax;
    int nbad, stall_bad, resume_x;
    logic [23:0] first_rgb;
    logic [23:0] pix [0:4][0:99];
    logic [23:0] exp_const;

`ifdef PATTERN_BORDER_EN
    localparam logic [23:0] E00 = 24'hFFFFFF, E994 = 24'hFFFFFF, E500 = 24'hFFFFFF;
`else
    localparam logic [23:0] E00 = 24'h000000, E994 = 24'h630467, E500 = 24'h320032;
`endif

    pattern_frame_gen dut (
        .clkmm(clkmm), .rst_l(rst_l), .iReadyToRead(rdy), .iImageTypeTest(typ),
        .iRed(red), .iGreen(grn), .iBlue(blu),
        .oValid(oValid), .oLvalid(oLvalid), .oFvalid(oFvalid), .oSof(oSof), .oEof(oEof),
        .oRgb(oRgb), .oX(oX), .oY(oY), .oDone(oDone));

    pattern_frame_gen #(.NUM_FRAMES(0)) dut_fr (
        .clkmm(clkmm), .rst_l(rst_l), .iReadyToRead(rdy), .iImageTypeTest(typ),
        .iRed(red), .iGreen(grn), .iBlue(blu),
        .oValid(fValid), .oLvalid(fLvalid), .oFvalid(fFvalid), .oSof(fSof), .oEof(fEof),
        .oRgb(fRgb), .oX(fX), .oY(fY), .oDone(fDone));

    always #5 clkmm = ~clkmm;

    task automatic step();
        @(posedge clkmm);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame from IDLE to DONE; FSTART is t=0. Optional 7-cycle stall
    // before pixel (40,1) and a mid-frame iRed change at t=chg_t.
    task automatic run_frame(input bit stall_en, input int chg_t);
        int t, lrun, grun, sleft;
        bit in_gap, stalled, resume;
        t_sof = -1; t_done = -1; nval = 0; nsof = 0; neof = 0; nlines = 0;
        lmin = 9999; lmax = 0; gmin = 9999; gmax = 0; nbad = 0;
        stall_bad = 0; resume_x = -1; first_rgb = 'x;
        lrun = 0; grun = 0; sleft = 0; in_gap = 0; stalled = 0; resume = 0;
        rdy = 1'b1;
        step();
        t = 0;
        while (t < 800) begin
            step();
            t++;
            if (oDone) begin t_done = t; break; end
            if (t == chg_t) red = 8'h11;
            if (resume) begin resume_x = oValid ? int'(oX) : -2; resume = 0; end
            if (oValid) begin
                nval++;
                if (nval == 1) first_rgb = oRgb;
                if (oY < 5 && oX < 100) pix[oY][oX] = oRgb;
                if (oSof) begin nsof++; t_sof = t; end
                if (oEof) neof++;
                if (typ && oRgb !== exp_const) nbad++;
            end
            if (oLvalid) begin
                if (lrun == 0) begin
                    nlines++;
                    if (in_gap) begin
                        if (grun < gmin) gmin = grun;
                        if (grun > gmax) gmax = grun;
                    end
                end
                lrun++; grun = 0; in_gap = 0;
            end else begin
                if (lrun > 0) begin
                    if (lrun < lmin) lmin = lrun;
                    if (lrun > lmax) lmax = lrun;
                    lrun = 0; in_gap = 1;
                end
                if (in_gap && oFvalid) grun++;
            end
            if (sleft > 0) begin
                if (oValid || oX != 12'd39) stall_bad++;
                sleft--;
                if (sleft == 0) begin rdy = 1'b1; resume = 1; end
            end else if (stall_en && !stalled && oValid && oX == 12'd39 && oY == 12'd1) begin
                rdy = 1'b0; sleft = 7; stalled = 1;
            end
        end
        rdy = 1'b0;
        step();
    endtask

    initial begin
        int t, fsof, feof, fgmin, fgmax, fgrun, tsof2, tsof3;
        bit fdone, fseen, found;
        rst_l = 1'b1; rdy = 1'b0; typ = 1'b0; red = 8'h00; grn = 8'h00; blu = 8'h00;
        exp_const = 24'h0;
        #1 rst_l = 1'b0;
        #2;
        chk("reset_flags", {30'd0, oValid, oLvalid, oFvalid, oSof, oEof, oDone,
                            fValid, fLvalid, fFvalid, fSof, fEof, fDone}, 32'd0);
        chk("reset_rgb", oRgb, 24'h0);
        chk("reset_xy", {oX, oY}, 24'h0);
        repeat (3) step();
        rst_l = 1'b1;
        step();
        chk("idle_fvalid", oFvalid, 1'b0);

        run_frame(1'b0, -1);
        chk("ramp_nval", nval, 500);
        chk("ramp_lines", nlines, 5);
        chk("ramp_lmin", lmin, 100);
        chk("ramp_lmax", lmax, 100);
        chk("ramp_gmin", gmin, 10);
        chk("ramp_gmax", gmax, 10);
        chk("ramp_nsof", nsof, 1);
        chk("ramp_neof", neof, 1);
        chk("ramp_tsof", t_sof, 1);
        chk("ramp_tdone", t_done, 551);
        chk("ramp_px3_2", pix[2][3], 24'h030201);
        chk("ramp_px0_0", pix[0][0], E00);
        chk("ramp_px99_4", pix[4][99], E994);
        chk("ramp_px50_0", pix[0][50], E500);
        chk("ramp_px50_2", pix[2][50], 24'h320230);
        chk("idle_after_done", oDone, 1'b0);

        typ = 1'b1; red = 8'hA5; grn = 8'h5A; blu = 8'h0F;
`ifdef PATTERN_BORDER_EN
        exp_const = 24'hA55A0F;
        run_frame(1'b0, 200);
        chk("const_interior", pix[2][50], 24'hA55A0F);
`else
        exp_const = 24'hA55A0F;
        run_frame(1'b0, 200);
        chk("const_bad", nbad, 0);
`endif
        chk("const_nval", nval, 500);
        chk("const_tdone", t_done, 551);
        exp_const = 24'h115A0F;
        run_frame(1'b0, -1);
        chk("const_next_interior", pix[2][50], 24'h115A0F);

        typ = 1'b0;
        run_frame(1'b1, -1);
        chk("stall_nval", nval, 500);
        chk("stall_tdone", t_done, 558);
        chk("stall_hold", stall_bad, 0);
        chk("stall_resume_x", resume_x, 40);

        rdy = 1'b1;
        step();
        found = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (oValid && oX == 12'd55 && oY == 12'd3) begin found = 1; break; end
        end
        chk("areset_reach", found, 1'b1);
        #2 rst_l = 1'b0;
        #1;
        chk("areset_flags", {26'd0, oValid, oLvalid, oFvalid, oSof, oEof, oDone}, 32'd0);
        chk("areset_rgb_xy", {oRgb, oX[3:0], oY[3:0]}, 32'd0);
        chk("areset_xy_full", {oX, oY}, 24'h0);
        step();
        rst_l = 1'b1;
        step();
        chk("areset_fstart", {oFvalid, oValid}, 2'b10);
        step();
        chk("areset_sof", {oValid, oSof}, 2'b11);
        chk("areset_sof_xy", {oX, oY}, 24'h0);

        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        fsof = 0; feof = 0; fgmin = 9999; fgmax = 0; fgrun = 0; fdone = 0; fseen = 0;
        tsof2 = 0; tsof3 = 0;
        for (t = 0; t < 2500 && fsof < 4; t++) begin
            step();
            if (fDone) fdone = 1;
            if (fValid && fSof) begin
                fsof++;
                if (fsof == 2) tsof2 = t;
                if (fsof == 3) tsof3 = t;
            end
            if (fValid && fEof) feof++;
            if (fFvalid) begin
                if (fseen && fgrun > 0) begin
                    if (fgrun < fgmin) fgmin = fgrun;
                    if (fgrun > fgmax) fgmax = fgrun;
                end
                fseen = 1; fgrun = 0;
            end else if (fseen) fgrun++;
        end
        chk("free_nsof", fsof, 4);
        chk("free_neof", feof, 3);
        chk("free_gmin", fgmin, 10);
        chk("free_gmax", fgmax, 10);
        chk("free_period", tsof3 - tsof2, 551);
        chk("free_nodone", fdone, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
